// File: rtl/cmp_seq.sv
// ---------------------------------------------------------------------------
// cmp_seq : vector compare / min-max reduction sequencer
//
// Shares one combinational comparator across every element of a vector
// compare instruction. Each accepted element pair is presented to the
// comparator in the same cycle. The sequencer either records one mask bit
// per element (LT/LE/GT/GE) or folds the elements into a running min/max
// (MIN/MAX).
//
// Ports
//   module_clk_i, module_rst_i   clock (rising edge), async active-high reset
//   start_i, op_i, tc_i, vl_i    instruction launch; sampled only in IDLE
//   flush_i                      synchronous abort, highest priority
//   elem_valid_i / elem_ready_o  element stream handshake
//   elem_a_i, elem_b_i           element pair (vs2, vs1/scalar)
//   cmp_*_o / cmp_*_i            shared comparator drive and result
//   busy_o, done_o, err_o        status (done_o/err_o are one-cycle pulses)
//   mask_o, red_o                compare mask / reduction result
//
// Handshake: an element transfers on a cycle where elem_valid_i and
// elem_ready_o are both high. elem_ready_o is high in RUN only and does not
// depend on elem_valid_i. A producer holds its data stable while valid is
// high and ready is low; a low valid simply holds the sequencer state.
// ---------------------------------------------------------------------------
module cmp_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_VL     = 8,
  parameter int VL_W       = $clog2(MAX_VL + 1)
) (
  input  logic                  module_clk_i,
  input  logic                  module_rst_i,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic                  tc_i,
  input  logic [VL_W-1:0]       vl_i,
  input  logic                  flush_i,
  input  logic                  elem_valid_i,
  output logic                  elem_ready_o,
  input  logic [DATA_WIDTH-1:0] elem_a_i,
  input  logic [DATA_WIDTH-1:0] elem_b_i,
  output logic                  cmp_en_o,
  output logic [DATA_WIDTH-1:0] cmp_a_o,
  output logic [DATA_WIDTH-1:0] cmp_b_o,
  output logic                  cmp_leq_o,
  output logic                  cmp_tc_o,
  input  logic                  cmp_lt_le_i,
  input  logic                  cmp_ge_gt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [MAX_VL-1:0]     mask_o,
  output logic [DATA_WIDTH-1:0] red_o
);

  localparam logic [2:0] OP_LT  = 3'd0;
  localparam logic [2:0] OP_LE  = 3'd1;
  localparam logic [2:0] OP_GT  = 3'd2;
  localparam logic [2:0] OP_GE  = 3'd3;
  localparam logic [2:0] OP_MIN = 3'd4;
  localparam logic [2:0] OP_MAX = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_n;
  logic [2:0]              op_q;
  logic                    tc_q;
  logic [VL_W-1:0]         vl_q;
  logic [VL_W-1:0]         cnt_q;
  logic [VL_W-1:0]         cnt_inc;
  logic [MAX_VL-1:0]       mask_q;
  logic [DATA_WIDTH-1:0]   acc_q;
  logic                    err_q;

  logic                    hs;
  logic                    is_red;
  logic                    last_elem;
  logic                    leq_sel;
  logic                    elem_bit;
  logic                    take_new;
  logic                    start_ok;

  // ---------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------
  assign hs        = (state_q == S_RUN) && elem_valid_i;
  assign is_red    = (op_q == OP_MIN) || (op_q == OP_MAX);
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_elem = (cnt_inc == vl_q);
  assign start_ok  = start_i && (op_i <= OP_MAX);

  // LE and GT both need "a <= b" separated from "a > b"; LT and GE need
  // "a < b" separated from "a >= b". MIN uses strict less-than and MAX uses
  // strict greater-than so that ties keep the earlier element.
  always_comb begin
    leq_sel  = 1'b0;
    elem_bit = cmp_lt_le_i;
    take_new = 1'b0;
    case (op_q)
      OP_LT:   begin leq_sel = 1'b0; elem_bit = cmp_lt_le_i; end
      OP_LE:   begin leq_sel = 1'b1; elem_bit = cmp_lt_le_i; end
      OP_GT:   begin leq_sel = 1'b1; elem_bit = cmp_ge_gt_i; end
      OP_GE:   begin leq_sel = 1'b0; elem_bit = cmp_ge_gt_i; end
      OP_MIN:  begin leq_sel = 1'b0; take_new = cmp_lt_le_i; end
      OP_MAX:  begin leq_sel = 1'b1; take_new = cmp_ge_gt_i; end
      default: begin leq_sel = 1'b0; end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM next state (flush overrides every transition)
  // ---------------------------------------------------------------------
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_n = (vl_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (hs && last_elem) begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush_i) begin
      state_n = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    elem_ready_o = (state_q == S_RUN);
    busy_o       = (state_q == S_RUN);
    done_o       = (state_q == S_DONE);
    err_o        = err_q;
    mask_o       = mask_q;
    red_o        = acc_q;
    cmp_tc_o     = tc_q;
    cmp_en_o     = hs;
    cmp_a_o      = '0;
    cmp_b_o      = '0;
    cmp_leq_o    = 1'b0;
    // The comparator sees zero operands whenever it is not in use.
    if (hs) begin
      cmp_a_o   = elem_a_i;
      cmp_b_o   = is_red ? acc_q : elem_b_i;
      cmp_leq_o = leq_sel;
    end
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge module_clk_i or posedge module_rst_i) begin
    if (module_rst_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_LT;
      tc_q    <= 1'b0;
      vl_q    <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      err_q   <= 1'b0;
      if (flush_i) begin
        cnt_q  <= '0;
        mask_q <= '0;
        acc_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_ok) begin
              op_q   <= op_i;
              tc_q   <= tc_i;
              vl_q   <= vl_i;
              cnt_q  <= '0;
              mask_q <= '0;
              acc_q  <= '0;
            end else if (start_i) begin
              // Illegal opcode: flag it, leave previous results intact.
              err_q <= 1'b1;
            end
          end
          S_RUN: begin
            if (hs) begin
              cnt_q <= cnt_inc;
              if (is_red) begin
                // The first element seeds the accumulator; the comparator
                // result for it is meaningless and ignored.
                if ((cnt_q == '0) || take_new) begin
                  acc_q <= elem_a_i;
                end
              end else begin
                for (int i = 0; i < MAX_VL; i++) begin
                  if (cnt_q == VL_W'(i)) begin
                    mask_q[i] <= elem_bit;
                  end
                end
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmp_seq.sv
module tb_cmp_seq;

  localparam int DW     = 32;
  localparam int MAX_VL = 8;
  localparam int VL_W   = $clog2(MAX_VL + 1);

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------
  // DUT signals
  // -------------------------------------------------------------------
  logic              start = 1'b0;
  logic [2:0]        op_in = 3'd0;
  logic              tc_in = 1'b0;
  logic [VL_W-1:0]   vl_in = '0;
  logic              flush = 1'b0;
  logic              elem_valid = 1'b0;
  logic              elem_ready;
  logic [DW-1:0]     elem_a = '0;
  logic [DW-1:0]     elem_b = '0;
  logic              cmp_en;
  logic [DW-1:0]     cmp_a;
  logic [DW-1:0]     cmp_b;
  logic              cmp_leq;
  logic              cmp_tc;
  logic              cmp_lt_le;
  logic              cmp_ge_gt;
  logic              busy;
  logic              done;
  logic              err;
  logic [MAX_VL-1:0] mask;
  logic [DW-1:0]     red;

  cmp_seq #(.DATA_WIDTH(DW), .MAX_VL(MAX_VL), .VL_W(VL_W)) dut (
    .module_clk_i (clk),
    .module_rst_i (rst),
    .start_i      (start),
    .op_i         (op_in),
    .tc_i         (tc_in),
    .vl_i         (vl_in),
    .flush_i      (flush),
    .elem_valid_i (elem_valid),
    .elem_ready_o (elem_ready),
    .elem_a_i     (elem_a),
    .elem_b_i     (elem_b),
    .cmp_en_o     (cmp_en),
    .cmp_a_o      (cmp_a),
    .cmp_b_o      (cmp_b),
    .cmp_leq_o    (cmp_leq),
    .cmp_tc_o     (cmp_tc),
    .cmp_lt_le_i  (cmp_lt_le),
    .cmp_ge_gt_i  (cmp_ge_gt),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .mask_o       (mask),
    .red_o        (red)
  );

  // Behavioural shared comparator.
  logic c_lt, c_eq;
  always_comb begin
    c_lt      = cmp_tc ? ($signed(cmp_a) < $signed(cmp_b)) : (cmp_a < cmp_b);
    c_eq      = (cmp_a == cmp_b);
    cmp_lt_le = cmp_leq ? (c_lt | c_eq) : c_lt;
    cmp_ge_gt = cmp_leq ? !(c_lt | c_eq) : !c_lt;
  end

  // -------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  logic [MAX_VL+DW-1:0] exp_q[$];
  logic [DW-1:0]     a_arr [MAX_VL];
  logic [DW-1:0]     b_arr [MAX_VL];
  logic [MAX_VL-1:0] last_mask = '0;
  logic [DW-1:0]     last_red  = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit lt_f(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic tc);
    return tc ? ($signed(x) < $signed(y)) : (x < y);
  endfunction

  // Reference: plain element-wise compare or min/max fold (earliest wins ties).
  function automatic void ref_model(input logic [2:0] op, input logic tc, input int vl,
                                    output logic [MAX_VL-1:0] m, output logic [DW-1:0] r);
    m = '0;
    r = '0;
    for (int i = 0; i < vl; i++) begin
      case (op)
        3'd0: m[i] = lt_f(a_arr[i], b_arr[i], tc);
        3'd1: m[i] = !lt_f(b_arr[i], a_arr[i], tc);
        3'd2: m[i] = lt_f(b_arr[i], a_arr[i], tc);
        3'd3: m[i] = !lt_f(a_arr[i], b_arr[i], tc);
        3'd4: if (i == 0 || lt_f(a_arr[i], r, tc)) r = a_arr[i];
        3'd5: if (i == 0 || lt_f(r, a_arr[i], tc)) r = a_arr[i];
        default: ;
      endcase
    end
  endfunction

  // -------------------------------------------------------------------
  // Driver: one full instruction. gap: 0 = valid always high,
  // 1 = valid every other cycle, 2 = random valid. poke pulses start mid-run.
  // Called at posedge+1 with the DUT in IDLE.
  // -------------------------------------------------------------------
  task automatic run_instr(input logic [2:0] op, input logic tc, input int vl,
                           input int gap, input bit poke);
    logic [MAX_VL-1:0] m;
    logic [DW-1:0]     r;
    logic [DW-1:0]     acc;
    logic [MAX_VL+DW-1:0] e;
    logic              v;
    bit                is_red;
    int                idx, cyc;
    ref_model(op, tc, vl, m, r);
    exp_q.push_back({m, r});
    is_red = (op == 3'd4) || (op == 3'd5);
    start = 1'b1; op_in = op; tc_in = tc; vl_in = VL_W'(vl);
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0; acc = '0;
    while (idx < vl && cyc < 64) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      elem_valid = v;
      elem_a = a_arr[idx];
      elem_b = b_arr[idx];
      if (poke && cyc == 1) begin
        start = 1'b1; op_in = 3'd5 - op; tc_in = ~tc; vl_in = VL_W'(1);
      end
      #1;
      check_val("run_ready", elem_ready, 1);
      check_val("run_busy", busy, 1);
      check_val("run_done", done, 0);
      check_val("cmp_en", cmp_en, v);
      check_val("cmp_tc", cmp_tc, tc);
      if (v) begin
        check_val("cmp_a", cmp_a, a_arr[idx]);
        check_val("cmp_b", cmp_b, is_red ? acc : b_arr[idx]);
        check_val("cmp_leq", cmp_leq, (op == 3'd1 || op == 3'd2 || op == 3'd5));
        if (op == 3'd4 && (idx == 0 || lt_f(a_arr[idx], acc, tc))) acc = a_arr[idx];
        if (op == 3'd5 && (idx == 0 || lt_f(acc, a_arr[idx], tc))) acc = a_arr[idx];
        idx++;
      end else begin
        check_val("cmp_a_idle", cmp_a, 0);
        check_val("cmp_b_idle", cmp_b, 0);
        check_val("cmp_leq_idle", cmp_leq, 0);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    elem_valid = 1'b0;
    if (idx < vl) check_val("hs_timeout", idx, vl);
    #1;
    check_val("done_pulse", done, 1);
    check_val("done_busy", busy, 0);
    check_val("done_ready", elem_ready, 0);
    check_val("done_cmp_en", cmp_en, 0);
    if (gap == 0) check_val("latency", cyc, vl);
    e = exp_q.pop_front();
    check_val("mask", mask, e[MAX_VL+DW-1:DW]);
    check_val("red", red, e[DW-1:0]);
    last_mask = e[MAX_VL+DW-1:DW];
    last_red  = e[DW-1:0];
    @(posedge clk); #1;
    check_val("done_once", done, 0);
    check_val("mask_hold", mask, last_mask);
    check_val("red_hold", red, last_red);
  endtask

  task automatic load4(input logic [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
    a_arr[0] = a0; a_arr[1] = a1; a_arr[2] = a2; a_arr[3] = a3;
    b_arr[0] = b0; b_arr[1] = b1; b_arr[2] = b2; b_arr[3] = b3;
  endtask

  // -------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------
  initial begin
    logic [DW-1:0] t;
    for (int i = 0; i < MAX_VL; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    check_val("rst_ready", elem_ready, 0);
    check_val("rst_cmp_en", cmp_en, 0);
    check_val("rst_mask", mask, 0);
    check_val("rst_red", red, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LT signed
    load4(-1, 5, 3, 7, 0, 5, 4, 2);
    run_instr(3'd0, 1'b1, 4, 0, 1'b0);
    check_val("tp_lt_mask", last_mask, 8'b0000_0101);

    // GE unsigned, then signed; start pulsed mid-run must be ignored
    load4(32'hFFFF_FFFF, 1, 2, 0, 1, 1, 3, 0);
    run_instr(3'd3, 1'b0, 3, 0, 1'b1);
    check_val("tp_geu_mask", last_mask, 8'b0000_0011);
    run_instr(3'd3, 1'b1, 3, 2, 1'b0);
    check_val("tp_ges_mask", last_mask, 8'b0000_0010);

    // MAX signed, valid held high
    load4(3, -8, 9, 9, 0, 0, 0, 0);
    a_arr[4] = 0; a_arr[5] = -1; a_arr[6] = 2; a_arr[7] = 9;
    run_instr(3'd5, 1'b1, 8, 0, 1'b0);
    check_val("tp_max_red", last_red, 9);

    // MIN unsigned, valid every other cycle
    load4(7, 2, 32'h8000_0000, 2, 0, 0, 0, 0);
    a_arr[4] = 5;
    run_instr(3'd4, 1'b0, 5, 1, 1'b0);
    check_val("tp_min_red", last_red, 2);

    // vl = 0
    run_instr(3'd1, 1'b0, 0, 0, 1'b0);
    check_val("tp_vl0_mask", last_mask, 0);

    // Illegal opcode
    load4(7, 7, 7, 7, 1, 1, 1, 1);
    run_instr(3'd2, 1'b0, 2, 0, 1'b0);
    start = 1'b1; op_in = 3'd6; vl_in = VL_W'(3);
    @(posedge clk); #1;
    start = 1'b0;
    check_val("err_pulse", err, 1);
    check_val("err_busy", busy, 0);
    check_val("err_mask", mask, last_mask);
    @(posedge clk); #1;
    check_val("err_once", err, 0);
    check_val("err_busy2", busy, 0);
    check_val("err_done", done, 0);

    // Flush after 2 of 6 elements (flush wins over the handshake)
    for (int i = 0; i < MAX_VL; i++) begin a_arr[i] = 0; b_arr[i] = 1; end
    start = 1'b1; op_in = 3'd0; tc_in = 1'b0; vl_in = VL_W'(6);
    @(posedge clk); #1;
    start = 1'b0; elem_valid = 1'b1; elem_a = 0; elem_b = 1;
    repeat (2) begin @(posedge clk); #1; end
    check_val("pre_flush_mask", mask, 8'b0000_0011);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; elem_valid = 1'b0;
    check_val("flush_busy", busy, 0);
    check_val("flush_ready", elem_ready, 0);
    check_val("flush_done", done, 0);
    check_val("flush_mask", mask, 0);
    @(posedge clk); #1;
    check_val("flush_nodone", done, 0);

    // Async reset mid-run
    start = 1'b1; op_in = 3'd5; tc_in = 1'b0; vl_in = VL_W'(5);
    @(posedge clk); #1;
    start = 1'b0; elem_valid = 1'b1; elem_a = 32'h55;
    repeat (2) begin @(posedge clk); #1; end
    check_val("pre_rst_red", red, 32'h55);
    #2 rst = 1'b1;
    #1;
    check_val("arst_busy", busy, 0);
    check_val("arst_ready", elem_ready, 0);
    check_val("arst_cmp_en", cmp_en, 0);
    check_val("arst_red", red, 0);
    check_val("arst_mask", mask, 0);
    elem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized instructions
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < MAX_VL; i++) begin
        t = DW'($urandom_range(0, 6)) - DW'(3);
        a_arr[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom()) : t;
        t = DW'($urandom_range(0, 6)) - DW'(3);
        b_arr[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom()) : t;
      end
      run_instr(3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, MAX_VL)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)));
    end

    check_val("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmp_seq.md
Name: cmp_seq

Overview:
Sequencer that shares one combinational comparator instance (two-operand, LEQ/TC controlled, LT_LE/GE_GT outputs, operands zeroed when not enabled) across all elements of a vector compare instruction. For each instruction it streams element pairs from the operand-read stage and drives the comparator one element per cycle. It either builds a per-element result mask (vector compare) or accumulates a min/max scalar (vector reduction). It sits between the issue stage and the shared comparator in the ALU lane.

Parameters:
DATA_WIDTH, 32, element width, equal to the comparator width
MAX_VL, 8, maximum elements per instruction; mask width
VL_W, $clog2(MAX_VL+1), width of the vector-length field

Ports:
module_clk_i  in  1  clock, rising edge
module_rst_i  in  1  asynchronous reset, active-high
start_i  in  1  launch instruction; sampled only in IDLE
op_i  in  3  0=LT 1=LE 2=GT 3=GE 4=MIN 5=MAX (reductions); 6,7 illegal
tc_i  in  1  1=signed (two's complement), 0=unsigned
vl_i  in  VL_W  element count, 0..MAX_VL
flush_i  in  1  synchronous abort
elem_valid_i  in  1  element pair valid
elem_ready_o  out  1  sequencer accepts element
elem_a_i  in  DATA_WIDTH  element of vs2
elem_b_i  in  DATA_WIDTH  element of vs1/scalar (ignored for MIN/MAX)
cmp_en_o  out  1  comparator enable
cmp_a_o  out  DATA_WIDTH  comparator A
cmp_b_o  out  DATA_WIDTH  comparator B
cmp_leq_o  out  1  comparator LEQ
cmp_tc_o  out  1  comparator TC
cmp_lt_le_i  in  1  comparator LT_LE result
cmp_ge_gt_i  in  1  comparator GE_GT result
busy_o  out  1  instruction in progress
done_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle illegal-op pulse
mask_o  out  MAX_VL  compare mask; bit i = element i
red_o  out  DATA_WIDTH  reduction result

Behaviour:
- Reset (async): state=IDLE; busy_o, done_o, err_o, elem_ready_o, cmp_en_o = 0; mask_o=0; red_o=0; internal counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start_i=1, legal op: latch op, tc, vl; clear mask_o and red_o; go to RUN next cycle. busy_o=1 from that cycle.
- IDLE, start_i=1, op 6 or 7: err_o pulses next cycle; stay IDLE; results untouched.
- IDLE, start_i=1, vl_i=0: go to DONE directly; mask_o=0, red_o=0.
- RUN: elem_ready_o=1. A handshake is elem_valid_i & elem_ready_o. cmp_en_o = handshake (combinational). cmp_tc_o = latched tc.
- Compare ops, cmp_a_o=elem_a_i, cmp_b_o=elem_b_i:
  - LT: leq=0, bit=lt_le
  - LE: leq=1, bit=lt_le
  - GT: leq=1, bit=ge_gt
  - GE: leq=0, bit=ge_gt
  - mask_o[count] registers the bit on handshake.
- MIN/MAX:
  - First handshake (count=0) loads acc=elem_a_i; the comparator result is ignored.
  - Later handshakes: cmp_a_o=elem_a_i, cmp_b_o=acc.
  - MIN: leq=0; acc<=elem_a_i if lt_le=1.
  - MAX: leq=1; acc<=elem_a_i if ge_gt=1.
  - Ties keep the earlier element.
  - red_o tracks acc.
- When cmp_en_o=0, cmp_a_o and cmp_b_o are 0 and cmp_leq_o is 0.
- Counter increments per handshake. A handshake with count==vl-1 moves the FSM to DONE on the next cycle; elem_ready_o=0 from that cycle.
- Back-to-back elem_valid_i gives one element per cycle, no bubbles. A stalled valid holds state.
- DONE: done_o=1 for exactly one cycle; busy_o=0 in DONE; return to IDLE. mask_o bits >= vl are 0. mask_o and red_o hold until the next accepted start_i.
- start_i while RUN or DONE is ignored. It is not queued.
- flush_i (any state): next cycle IDLE; no done_o; mask_o and red_o cleared. flush_i has priority over a handshake in the same cycle and over start_i.
- Reset mid-RUN: immediate return to reset values.

Test Plan:
- LT signed, vl=4, a={-1,5,3,7}, b={0,5,4,2} -> mask_o=8'b0000_0101, done_o one cycle after 4th handshake, cmp_leq_o=0.
- GE unsigned, vl=3, a={0xFFFFFFFF,1,2}, b={1,1,3} -> mask_o=8'b0000_0011; same data signed -> 8'b0000_0010.
- MAX signed, vl=8, a={3,-8,9,9,0,-1,2,9} -> red_o=9 (first 9 retained), done_o at cycle 10 after start, elem_valid_i held high.
- MIN unsigned with elem_valid_i toggling every other cycle, vl=5, a={7,2,0x80000000,2,5} -> red_o=2, 5 handshakes, cmp_en_o high only on handshake cycles.
- vl=0 start -> done_o 2 cycles after start, mask_o=0, no cmp_en_o; op=6 -> err_o pulse, busy_o stays 0.
- flush_i after 2 of 6 elements -> IDLE next cycle, no done_o, mask_o=0; start_i during RUN ignored; async reset mid-RUN -> all outputs 0 immediately.
